// File: rtl/gated_delay_pkg.sv
// Shared types, default parameters and helpers for the gated delay pipeline.
package gated_delay_pkg;

    typedef enum logic [0:0] {
        GDP_ZERO = 1'b0,
        GDP_HOLD = 1'b1
    } gate_mode_e;

    localparam int unsigned DefWidth    = 8;
    localparam int unsigned DefDepth    = 2;
    localparam int unsigned DefChannels = 4;
    localparam int unsigned DefCntW     = 8;

    // Saturating increment of a counter 'width' bits wide (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/gdp_channel.sv
// One channel: data delay line, two-stage control path, gated output register
// and saturating suppression counter.
module gdp_channel
    import gated_delay_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned DEPTH     = DefDepth,
    parameter gate_mode_e  GATE_MODE = GDP_ZERO,
    parameter int unsigned CNT_W     = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel_in,
    input  logic [WIDTH-1:0] thr_in,
    input  logic             valid_tail,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] supp_cnt
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic             sel_q;
    logic [WIDTH-1:0] thr_q;
    logic             gate_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            data_q[0] <= in_data;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
            end
        end
    end

    // Control latency is fixed at three edges regardless of DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= 1'b0;
            thr_q  <= '0;
            gate_q <= 1'b0;
        end else begin
            sel_q  <= sel_in;
            thr_q  <= thr_in + WIDTH'(1);
            gate_q <= sel_q ? 1'b0 : (thr_q != '0);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (valid_tail && gate_q) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (!gate_q) begin
                out_q <= data_q[DEPTH-1];
            end else if (GATE_MODE == GDP_ZERO) begin
                out_q <= '0;
            end
        end
    end

    assign out_data = out_q;
    assign supp_cnt = cnt_q;

endmodule

// File: rtl/gated_delay_pipe.sv
// Multi-channel gated delay pipeline: shared valid pipe plus CHANNELS
// independent gated data channels.
module gated_delay_pipe
    import gated_delay_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned DEPTH     = DefDepth,
    parameter int unsigned CHANNELS  = DefChannels,
    parameter gate_mode_e  GATE_MODE = GDP_ZERO,
    parameter int unsigned CNT_W     = DefCntW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       sel_in,
    input  logic [CHANNELS*WIDTH-1:0] thr_in,
    input  logic                      cnt_clr,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS*CNT_W-1:0] supp_cnt
);

    logic [DEPTH-1:0] valid_q;
    logic             out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            valid_q[0] <= in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
            out_valid_q <= valid_q[DEPTH-1];
        end
    end

    assign out_valid = out_valid_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gdp_channel #(
            .WIDTH     (WIDTH),
            .DEPTH     (DEPTH),
            .GATE_MODE (GATE_MODE),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_data    (in_data[c*WIDTH +: WIDTH]),
            .sel_in     (sel_in[c]),
            .thr_in     (thr_in[c*WIDTH +: WIDTH]),
            .valid_tail (valid_q[DEPTH-1]),
            .cnt_clr    (cnt_clr),
            .out_data   (out_data[c*WIDTH +: WIDTH]),
            .supp_cnt   (supp_cnt[c*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_gated_delay_pipe.sv
// Bench for gated_delay_pipe: two instances (zero mode DEPTH=2 CNT_W=3, hold mode
// DEPTH=4 CNT_W=8) driven in parallel and compared against an input-history model.
module tb_gated_delay_pipe;
    import gated_delay_pkg::*;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic [3:0]  sel;
        logic [31:0] thr;
        logic        clr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  sel_in;
    logic [31:0] thr_in;
    logic        cnt_clr;
    logic        out_valid_a, out_valid_b;
    logic [31:0] out_data_a, out_data_b;
    logic [11:0] supp_cnt_a;
    logic [31:0] supp_cnt_b;

    gated_delay_pipe #(
        .WIDTH(8), .DEPTH(2), .CHANNELS(4), .GATE_MODE(GDP_ZERO), .CNT_W(3)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .sel_in(sel_in), .thr_in(thr_in), .cnt_clr(cnt_clr),
        .out_valid(out_valid_a), .out_data(out_data_a), .supp_cnt(supp_cnt_a)
    );

    gated_delay_pipe #(
        .WIDTH(8), .DEPTH(4), .CHANNELS(4), .GATE_MODE(GDP_HOLD), .CNT_W(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .sel_in(sel_in), .thr_in(thr_in), .cnt_clr(cnt_clr),
        .out_valid(out_valid_b), .out_data(out_data_b), .supp_cnt(supp_cnt_b)
    );

    always #5 clk = ~clk;

    rec_t hist [4096];
    int   e_cnt = 0;
    int   base  = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] exp_data [2][4];
    int         exp_cnt  [2][4];
    logic       exp_valid [2];

    function automatic rec_t reset_rec();
        rec_t r;
        r.valid = 1'b0; r.data = '0; r.sel = 4'hF; r.thr = '0; r.clr = 1'b0;
        return r;
    endfunction

    function automatic rec_t rec(input int i);
        if (i < base) return reset_rec();
        return hist[i];
    endfunction

    function automatic rec_t mk(input logic v, input logic [31:0] d, input logic [3:0] s,
                                input logic [31:0] t, input logic c);
        rec_t r;
        r.valid = v; r.data = d; r.sel = s; r.thr = t; r.clr = c;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.valid = ($urandom_range(0, 3) != 0);
        r.data  = $urandom;
        r.sel   = 4'($urandom);
        for (int c = 0; c < 4; c++) begin
            case ($urandom_range(0, 2))
                0:       r.thr[c*8 +: 8] = 8'hFF;
                1:       r.thr[c*8 +: 8] = 8'h00;
                default: r.thr[c*8 +: 8] = 8'($urandom);
            endcase
        end
        r.clr = ($urandom_range(0, 15) == 0);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 2; d++) begin
            exp_valid[d] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                exp_data[d][c] = '0;
                exp_cnt[d][c]  = 0;
            end
        end
    endtask

    // Output written at edge E: data/valid from input cycle E-DEPTH-1,
    // gate from control of cycle E-3, clear from cycle E-1.
    task automatic model_edge(input int e);
        for (int d = 0; d < 2; d++) begin
            int   depth = (d == 0) ? 2 : 4;
            int   cmax  = (d == 0) ? 7 : 255;
            rec_t dr    = rec(e - depth - 1);
            rec_t cr    = rec(e - 3);
            rec_t kr    = rec(e - 1);
            exp_valid[d] = dr.valid;
            for (int c = 0; c < 4; c++) begin
                logic gated;
                gated = !cr.sel[c] && (cr.thr[c*8 +: 8] != 8'hFF);
                if (!gated) exp_data[d][c] = dr.data[c*8 +: 8];
                else if (d == 0) exp_data[d][c] = 8'h00;
                if (kr.clr) exp_cnt[d][c] = 0;
                else if (dr.valid && gated && exp_cnt[d][c] < cmax) exp_cnt[d][c]++;
            end
        end
    endtask

    task automatic check_all();
        chk("a.valid", 32'(out_valid_a), 32'(exp_valid[0]));
        chk("b.valid", 32'(out_valid_b), 32'(exp_valid[1]));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("a.data[%0d]", c), 32'(out_data_a[c*8 +: 8]), 32'(exp_data[0][c]));
            chk($sformatf("b.data[%0d]", c), 32'(out_data_b[c*8 +: 8]), 32'(exp_data[1][c]));
            chk($sformatf("a.cnt[%0d]", c), 32'(supp_cnt_a[c*3 +: 3]), 32'(exp_cnt[0][c]));
            chk($sformatf("b.cnt[%0d]", c), 32'(supp_cnt_b[c*8 +: 8]), 32'(exp_cnt[1][c]));
        end
    endtask

    task automatic step(input rec_t r);
        hist[e_cnt] = r;
        in_valid = r.valid;
        in_data  = r.data;
        sel_in   = r.sel;
        thr_in   = r.thr;
        cnt_clr  = r.clr;
        @(posedge clk);
        e_cnt++;
        model_edge(e_cnt);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; sel_in = '0; thr_in = '0; cnt_clr = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        base  = e_cnt;

        // Pass-through with all selects forced open.
        step(mk(1'b1, 32'h44332211, 4'hF, 32'h0000_0000, 1'b0));
        step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
        step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
        chk("pass.a.data", out_data_a, 32'h44332211);
        chk("pass.a.valid", 32'(out_valid_a), 32'd1);
        repeat (3) step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));

        // Threshold wrap: ch0 0xFF passes, ch1 0x00 is gated.
        repeat (5) step(mk(1'b1, $urandom, 4'h0, 32'hFFFF_00FF, 1'b0));
        repeat (5) step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));

        // Hold mode: 0x5A passes, then gate closes on 0x77 with in_valid low.
        repeat (3) step(mk(1'b1, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0));
        repeat (7) step(mk(1'b0, 32'h7777_7777, 4'h0, 32'h0, 1'b0));
        chk("hold.b.data0", 32'(out_data_b[7:0]), 32'h5A);

        // Saturation of ch2 then clear on a suppressed beat.
        step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b1));
        repeat (10) step(mk(1'b1, $urandom, 4'hB, 32'h0, 1'b0));
        repeat (4) step(mk(1'b0, 32'h0, 4'hB, 32'h0, 1'b0));
        chk("sat.a.cnt2", 32'(supp_cnt_a[8:6]), 32'd7);
        repeat (5) step(mk(1'b1, $urandom, 4'hB, 32'h0, 1'b0));
        step(mk(1'b1, $urandom, 4'hB, 32'h0, 1'b1));
        repeat (4) step(mk(1'b1, $urandom, 4'hB, 32'h0, 1'b0));

        // Single-cycle select drop alongside marker 0x99.
        repeat (6) step(mk(1'b1, 32'h0101_0101, 4'hF, 32'h0, 1'b0));
        step(mk(1'b1, 32'h9999_9999, 4'h0, 32'h0, 1'b0));
        repeat (4) step(mk(1'b1, 32'h0202_0202, 4'hF, 32'h0, 1'b0));
        chk("skew.b.data0", 32'(out_data_b[7:0]), 32'h99);
        repeat (3) step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));

        // Random traffic.
        for (int i = 0; i < 200; i++) step(rand_rec());

        // Reset mid-stream with 0xA5 in flight.
        step(mk(1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0));
        step(mk(1'b1, 32'hA5A5_A5A5, 4'hF, 32'h0, 1'b0));
        rst_n = 1'b0;
        clear_model();
        #1;
        check_all();
        @(posedge clk);
        e_cnt++;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        base  = e_cnt;
        repeat (2) step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
        chk("rst.a.valid", 32'(out_valid_a), 32'd0);
        step(mk(1'b1, 32'hC3C3_C3C3, 4'hF, 32'h0, 1'b0));
        repeat (2) step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));
        chk("rst.a.data", out_data_a, 32'hC3C3_C3C3);
        for (int i = 0; i < 40; i++) step(rand_rec());
        repeat (6) step(mk(1'b0, 32'h0, 4'hF, 32'h0, 1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
